// File: rtl/cmd_frame_pkg.sv
// Shared types and constants for the UART command-frame decoder.
// Holds the frame FSM state encoding and the error codes reported on err_code.
package cmd_frame_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PAYLOAD = 2'd1,
    CHECK   = 2'd2
  } state_t;

  localparam logic [2:0] ERR_NONE     = 3'd0;
  localparam logic [2:0] ERR_BAD_CMD  = 3'd1;
  localparam logic [2:0] ERR_TIMEOUT  = 3'd2;
  localparam logic [2:0] ERR_CHECKSUM = 3'd3;
  localparam logic [2:0] ERR_OVERFLOW = 3'd4;

endpackage

// File: rtl/cmd_byte_timeout.sv
// Inter-byte timeout counter: counts idle sclk cycles inside a frame and
// flags the cycle in which the limit is reached without a byte arriving.
module cmd_byte_timeout #(
  parameter int TIMEOUT_CYC = 50000
) (
  input  logic sclk,
  input  logic reset,
  input  logic clr,
  input  logic run,
  output logic expire
);

  localparam int TW = $clog2(TIMEOUT_CYC);
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_CYC - 1);

  logic [TW-1:0] tcnt_reg;

  // A byte in the expiry cycle drives clr, which suppresses expire.
  assign expire = run && !clr && (tcnt_reg == TMAX);

  always_ff @(posedge sclk or negedge reset) begin
    if (!reset) begin
      tcnt_reg <= '0;
    end else if (clr || expire) begin
      tcnt_reg <= '0;
    end else if (run) begin
      tcnt_reg <= tcnt_reg + TW'(1);
    end
  end

endmodule

// File: rtl/cmd_frame_decode.sv
// UART command-frame decoder: parses CMD [PAYLOAD] [CHK], streams payload into
// the write FIFO, and reports triggers, aborts and error codes (all registered).
module cmd_frame_decode
  import cmd_frame_pkg::*;
#(
  parameter int          PAYLOAD_LEN = 4,
  parameter logic [7:0]  WR_CMD      = 8'h55,
  parameter logic [7:0]  RD_CMD      = 8'haa,
  parameter bit          CHK_EN      = 1'b1,
  parameter int          TIMEOUT_CYC = 50000
) (
  input  logic       sclk,
  input  logic       reset,
  input  logic       uart_flag,
  input  logic [7:0] uart_data,
  input  logic       wfifo_full,
  output logic       wfifo_wr_en,
  output logic [7:0] wfifo_data,
  output logic       wr_trig,
  output logic       rd_trig,
  output logic       wr_abort,
  output logic [2:0] err_code,
  output logic       busy
);

  localparam int CW = $clog2(PAYLOAD_LEN + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(PAYLOAD_LEN - 1);

  state_t        state_reg;
  logic [CW-1:0] cnt_reg;
  logic [7:0]    chk_reg;
  logic          tmo_clr;
  logic          tmo_run;
  logic          tmo_expire;

  assign tmo_clr = (state_reg == IDLE) || uart_flag;
  assign tmo_run = (state_reg != IDLE);

  cmd_byte_timeout #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_timeout (
    .sclk   (sclk),
    .reset  (reset),
    .clr    (tmo_clr),
    .run    (tmo_run),
    .expire (tmo_expire)
  );

  always_ff @(posedge sclk or negedge reset) begin
    if (!reset) begin
      state_reg   <= IDLE;
      cnt_reg     <= '0;
      chk_reg     <= '0;
      wfifo_wr_en <= 1'b0;
      wfifo_data  <= '0;
      wr_trig     <= 1'b0;
      rd_trig     <= 1'b0;
      wr_abort    <= 1'b0;
      err_code    <= ERR_NONE;
      busy        <= 1'b0;
    end else begin
      wfifo_wr_en <= 1'b0;
      wr_trig     <= 1'b0;
      rd_trig     <= 1'b0;
      wr_abort    <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (uart_flag) begin
            if (uart_data == RD_CMD) begin
              rd_trig <= 1'b1;
            end else if (uart_data == WR_CMD) begin
              state_reg <= PAYLOAD;
              busy      <= 1'b1;
              cnt_reg   <= '0;
              chk_reg   <= '0;
            end else begin
              err_code <= ERR_BAD_CMD;
            end
          end
        end

        PAYLOAD: begin
          if (uart_flag) begin
            if (wfifo_full) begin
              // Byte is dropped; the whole frame is discarded downstream.
              wr_abort  <= 1'b1;
              err_code  <= ERR_OVERFLOW;
              state_reg <= IDLE;
              busy      <= 1'b0;
            end else begin
              wfifo_wr_en <= 1'b1;
              wfifo_data  <= uart_data;
              chk_reg     <= chk_reg ^ uart_data;
              if (cnt_reg == CNT_LAST) begin
                cnt_reg <= '0;
                if (CHK_EN) begin
                  state_reg <= CHECK;
                end else begin
                  wr_trig   <= 1'b1;
                  state_reg <= IDLE;
                  busy      <= 1'b0;
                end
              end else begin
                cnt_reg <= cnt_reg + CW'(1);
              end
            end
          end else if (tmo_expire) begin
            wr_abort  <= 1'b1;
            err_code  <= ERR_TIMEOUT;
            state_reg <= IDLE;
            busy      <= 1'b0;
          end
        end

        CHECK: begin
          if (uart_flag) begin
            if (uart_data == chk_reg) begin
              wr_trig <= 1'b1;
            end else begin
              wr_abort <= 1'b1;
              err_code <= ERR_CHECKSUM;
            end
            state_reg <= IDLE;
            busy      <= 1'b0;
          end else if (tmo_expire) begin
            wr_abort  <= 1'b1;
            err_code  <= ERR_TIMEOUT;
            state_reg <= IDLE;
            busy      <= 1'b0;
          end
        end

        default: begin
          state_reg <= IDLE;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule
